// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle datapath: opcodes, control-field encodings,
// funct codes and the internal 4-bit ALU operation codes.
package multicycle_pkg;

  typedef enum logic [5:0] {
    OP_LW     = 6'd0,
    OP_SW     = 6'd1,
    OP_RTYPE  = 6'd2,
    OP_BRANCH = 6'd3,
    OP_JUMP   = 6'd4
  } opcode_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_ADD_2 = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_e;

  // Unrecognised funct codes fall back to add.
  function automatic alu_op_e alu_control(input logic [1:0] alu_op, input logic [5:0] funct);
    case (alu_op)
      ALUOP_SUB: return ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_SUB: return ALU_SUB;
          FUNCT_AND: return ALU_AND;
          FUNCT_OR:  return ALU_OR;
          FUNCT_SLT: return ALU_SLT;
          default:   return ALU_ADD;
        endcase
      end
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/multicycle_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, async clear.
// Register 0 always reads zero and ignores writes. Debug port under MULTICYCLE_DP_DEBUG_EN.
module multicycle_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  input  logic [AW-1:0]     waddr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
`ifdef MULTICYCLE_DP_DEBUG_EN
  ,
  input  logic [AW-1:0]     dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
`endif
);

  logic [DATA_W-1:0] regs [NREGS];

  // NOTE: every entry is cleared on reset because the whole datapath must come up
  // zeroed; this makes the array flops rather than a RAM macro.
  // NOTE: sequential state is assigned with <= so all registers update from
  // pre-edge values, which is what gives the no-bypass read-during-write behaviour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

`ifdef MULTICYCLE_DP_DEBUG_EN
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
`endif

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle datapath (PC, IR, MDR, A, B, ALUOut, register file, ALU) driven by an external
// control FSM. Optional debug ports (dbg_raddr/dbg_rdata/dbg_pc) under MULTICYCLE_DP_DEBUG_EN.
module multicycle_datapath
  import multicycle_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                NREGS    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ALUSrcA,
  input  logic [1:0]        ALUSrcB,
  input  logic [1:0]        ALUOp,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic              RegDst,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic [1:0]        PCSource,
  output logic [5:0]        Op,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MULTICYCLE_DP_DEBUG_EN
  ,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [DATA_W-1:0] dbg_pc
`endif
);

  logic [DATA_W-1:0] pc, ir, mdr, a_reg, b_reg, alu_out;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic [DATA_W-1:0] src_a, src_b, imm_ext, alu_result, pc_next;
  logic [4:0]        rf_waddr;
  logic              zero, pc_en;
  alu_op_e           alu_ctl;

  assign imm_ext  = sign_ext(ir[15:0]);
  assign src_a    = ALUSrcA ? a_reg : pc;
  assign alu_ctl  = alu_control(ALUOp, ir[5:0]);
  assign rf_waddr = RegDst ? ir[15:11] : ir[20:16];
  assign rf_wdata = MemtoReg ? mdr : alu_out;

  // NOTE: each always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    src_b = b_reg;
    case (ALUSrcB)
      SRCB_B:    src_b = b_reg;
      SRCB_FOUR: src_b = DATA_W'(4);
      SRCB_IMM:  src_b = imm_ext;
      default:   src_b = imm_ext << 2;
    endcase
  end

  always_comb begin
    alu_result = src_a + src_b;
    case (alu_ctl)
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = src_a + src_b;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    pc_next = pc;
    case (PCSource)
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = alu_out;
      PCSRC_JUMP:   pc_next = {pc[DATA_W-1 -: 4], ir[25:0], 2'b00};
      default:      pc_next = pc;
    endcase
  end

  // PCSource=11 blocks the update even when PCWrite is asserted.
  assign pc_en = (PCWrite | (PCWriteCond & zero)) & (PCSource != PCSRC_HOLD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
    end else begin
      mdr     <= mem_rdata;
      a_reg   <= rf_rdata1;
      b_reg   <= rf_rdata2;
      alu_out <= alu_result;
      if (IRWrite) ir <= mem_rdata;
      if (pc_en)   pc <= pc_next;
    end
  end

  multicycle_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .raddr1   (ir[25:21]),
    .raddr2   (ir[20:16]),
    .waddr    (rf_waddr),
    .we       (RegWrite),
    .wdata    (rf_wdata),
    .rdata1   (rf_rdata1),
    .rdata2   (rf_rdata2)
`ifdef MULTICYCLE_DP_DEBUG_EN
    ,
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata)
`endif
  );

  assign Op        = ir[31:26];
  assign mem_addr  = IorD ? alu_out : pc;
  assign mem_wdata = b_reg;
  assign mem_rd    = MemRead;
  assign mem_wr    = MemWrite;

`ifdef MULTICYCLE_DP_DEBUG_EN
  assign dbg_pc = pc;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: a table of R-type ALU vectors plus
// hand-written sequences for reset, fetch, branch, jump, load/store and mid-instruction reset.
module tb_multicycle_datapath;
  import multicycle_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ALUSrcA, IorD, IRWrite, RegDst, RegWrite, MemtoReg, PCWrite, PCWriteCond;
  logic        MemRead, MemWrite;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [5:0]  Op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;
`ifdef MULTICYCLE_DP_DEBUG_EN
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata, dbg_pc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  multicycle_datapath #(
    .DATA_W  (32),
    .RESET_PC(32'h40),
    .NREGS   (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .PCSource   (PCSource),
    .Op         (Op),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata)
`ifdef MULTICYCLE_DP_DEBUG_EN
    ,
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .dbg_pc     (dbg_pc)
`endif
  );

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } rvec_t;

  rvec_t vecs [8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    ALUSrcA = 1'b0; ALUSrcB = 2'b00; ALUOp = 2'b00; MemRead = 1'b0; MemWrite = 1'b0;
    IorD = 1'b0; IRWrite = 1'b0; RegDst = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
    PCWrite = 1'b0; PCWriteCond = 1'b0; PCSource = 2'b00;
  endtask

  task automatic load_ir(input logic [31:0] word);
    set_idle();
    mem_rdata = word;
    IRWrite   = 1'b1;
    tick();
    IRWrite   = 1'b0;
  endtask

  // Route a value through MDR into rf[r].
  task automatic write_reg(input logic [4:0] r, input logic [31:0] val);
    load_ir({OP_LW, 5'd0, r, 16'd0});
    mem_rdata = val;
    tick();
    RegDst = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b1;
    tick();
    set_idle();
  endtask

  // Observe rf[r] through B on mem_wdata.
  task automatic read_reg(input string name, input logic [4:0] r, input logic [31:0] expected);
    load_ir({OP_LW, 5'd0, r, 16'd0});
    tick();
    check(name, mem_wdata, expected);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{FUNCT_SLT, 32'd5,          32'd7,          32'd1};
    vecs[1] = '{FUNCT_SUB, 32'd5,          32'd7,          32'hFFFF_FFFE};
    vecs[2] = '{FUNCT_ADD, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
    vecs[3] = '{FUNCT_AND, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'h00F0_000F};
    vecs[4] = '{FUNCT_OR,  32'hF000_0000,  32'h0000_000F,  32'hF000_000F};
    vecs[5] = '{FUNCT_SLT, 32'h8000_0000,  32'd1,          32'd1};
    vecs[6] = '{FUNCT_SLT, 32'd1,          32'h8000_0000,  32'd0};
    vecs[7] = '{6'b100111, 32'd3,          32'd4,          32'd7};

    // Reset state and strobe pass-through while in reset.
    reset = 1'b1;
    set_idle();
    mem_rdata = '0;
    MemRead = 1'b1; MemWrite = 1'b1;
    #3;
    check("rst_pc", mem_addr, 32'h40);
    check("rst_op", {26'd0, Op}, 32'd0);
    check("rst_mem_rd_hi", {31'd0, mem_rd}, 32'd1);
    check("rst_mem_wr_hi", {31'd0, mem_wr}, 32'd1);
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    check("rst_mem_rd_lo", {31'd0, mem_rd}, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_b", mem_wdata, 32'd0);
    IorD = 1'b1; #1;
    check("rst_aluout", mem_addr, 32'd0);
    IorD = 1'b0;
    ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ALUOp = ALUOP_ADD;
    tick();
    set_idle(); IorD = 1'b1; #1;
    check("rst_a_plus4", mem_addr, 32'd4);
    IorD = 1'b0; #1;
    check("rst_pc_held", mem_addr, 32'h40);

    // Fetch.
    mem_rdata = 32'h0800_0003;
    IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcA = 1'b0; ALUSrcB = SRCB_FOUR;
    PCSource = PCSRC_ALU; MemRead = 1'b1;
    #1;
    check("fetch_addr", mem_addr, 32'h40);
    check("fetch_mem_rd", {31'd0, mem_rd}, 32'd1);
    tick();
    set_idle(); #1;
    check("fetch_op", {26'd0, Op}, 32'd2);
    check("fetch_pc", mem_addr, 32'h44);

    // R-type table: S2 decode, S6 execute, S7 write-back.
    for (int i = 0; i < 8; i++) begin
      write_reg(5'd1, vecs[i].a);
      write_reg(5'd2, vecs[i].b);
      load_ir({OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, vecs[i].funct});
      tick();
      ALUSrcA = 1'b1; ALUSrcB = SRCB_B; ALUOp = ALUOP_FUNCT;
      tick();
      set_idle();
      RegDst = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b0; IorD = 1'b1;
      #1;
      check($sformatf("rtype%0d_aluout", i), mem_addr, vecs[i].exp);
      tick();
      set_idle();
      read_reg($sformatf("rtype%0d_rf3", i), 5'd3, vecs[i].exp);
    end

    // Same-edge write/read of rf[3] (currently 7): old value first, new one next edge.
    load_ir({OP_RTYPE, 5'd0, 5'd3, 5'd3, 5'd0, FUNCT_ADD});
    tick();
    ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ALUOp = ALUOP_ADD;
    tick();
    set_idle(); RegDst = 1'b1; RegWrite = 1'b1;
    tick();
    set_idle(); #1;
    check("collision_old", mem_wdata, 32'd7);
    tick();
    check("write_visible", mem_wdata, 32'd4);

    // Sign extension, rf[1]=3.
    load_ir({OP_LW, 5'd1, 5'd0, 16'hFFF8});
    tick();
    ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM;
    tick();
    IorD = 1'b1; #1;
    check("sext_neg", mem_addr, 32'hFFFF_FFFB);
    ALUSrcB = SRCB_IMM_SH2;
    tick();
    check("sext_sh2", mem_addr, 32'hFFFF_FFE3);
    set_idle();

    // Branch taken: A=B=9, ALUOut=9+0xF7=0x100.
    write_reg(5'd1, 32'd9);
    write_reg(5'd2, 32'd9);
    load_ir({OP_BRANCH, 5'd1, 5'd2, 16'h00F7});
    tick();
    ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_ADD;
    tick();
    set_idle();
    ALUSrcA = 1'b1; ALUSrcB = SRCB_B; ALUOp = ALUOP_SUB; PCWriteCond = 1'b1; PCSource = PCSRC_ALUOUT;
    tick();
    set_idle(); #1;
    check("beq_taken", mem_addr, 32'h100);

    // Branch not taken: A=9, B=8, ALUOut=0x200.
    write_reg(5'd2, 32'd8);
    load_ir({OP_BRANCH, 5'd1, 5'd2, 16'h01F7});
    tick();
    ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_ADD;
    tick();
    set_idle();
    ALUSrcA = 1'b1; ALUSrcB = SRCB_B; ALUOp = ALUOP_SUB; PCWriteCond = 1'b1; PCSource = PCSRC_ALUOUT;
    tick();
    set_idle(); #1;
    check("beq_not_taken", mem_addr, 32'h100);

    // Jump keeps PC[31:28]; PCSource=11 holds PC despite PCWrite.
    write_reg(5'd5, 32'h9000_0000);
    load_ir({OP_JUMP, 5'd5, 21'h00ABC});
    tick();
    PCWrite = 1'b1; PCSource = PCSRC_ALU; ALUSrcA = 1'b1; ALUSrcB = SRCB_B; ALUOp = ALUOP_ADD;
    tick();
    set_idle(); #1;
    check("pc_from_alu", mem_addr, 32'h9000_0000);
    PCWrite = 1'b1; PCSource = PCSRC_JUMP;
    tick();
    set_idle(); #1;
    check("jump_target", mem_addr, 32'h9280_2AF0);
`ifdef MULTICYCLE_DP_DEBUG_EN
    check("dbg_pc", dbg_pc, 32'h9280_2AF0);
`endif
    PCWrite = 1'b1; PCSource = PCSRC_HOLD; ALUSrcA = 1'b0; ALUSrcB = SRCB_FOUR;
    tick();
    set_idle(); #1;
    check("pcsrc_hold", mem_addr, 32'h9280_2AF0);

    // Load into rt=6.
    load_ir({OP_LW, 5'd0, 5'd6, 16'h0080});
    tick();
    ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM;
    tick();
    set_idle(); IorD = 1'b1; MemRead = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("lw_addr", mem_addr, 32'h80);
    check("lw_mem_rd", {31'd0, mem_rd}, 32'd1);
    tick();
    set_idle(); RegDst = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b1;
    tick();
    set_idle();
    read_reg("lw_rf6", 5'd6, 32'hDEAD_BEEF);

    // Store presents B and the write strobe.
    load_ir({OP_SW, 5'd0, 5'd6, 16'h0000});
    tick();
    MemWrite = 1'b1; #1;
    check("sw_mem_wr", {31'd0, mem_wr}, 32'd1);
    check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    set_idle();

    // Load into rt=0 is dropped.
    load_ir({OP_LW, 5'd0, 5'd0, 16'h0080});
    tick();
    ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM;
    tick();
    set_idle(); mem_rdata = 32'h1234_5678;
    tick();
    RegDst = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b1;
    tick();
    set_idle();
    read_reg("lw_rf0", 5'd0, 32'd0);

    // Reset mid-instruction (rf[1]=9, rf[2]=8, rf[3]=4), S7 signals held during reset.
    load_ir({OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, FUNCT_ADD});
    tick();
    check("midrst_pre_b", mem_wdata, 32'd8);
    ALUSrcA = 1'b1; ALUSrcB = SRCB_B; ALUOp = ALUOP_FUNCT;
    tick();
    set_idle(); RegDst = 1'b1; RegWrite = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_pc", mem_addr, 32'h40);
    check("midrst_op", {26'd0, Op}, 32'd0);
    check("midrst_b", mem_wdata, 32'd0);
    IorD = 1'b1; #1;
    check("midrst_aluout", mem_addr, 32'd0);
    repeat (2) tick();
    set_idle();
    reset = 1'b0;
    read_reg("midrst_rf3", 5'd3, 32'd0);
    read_reg("midrst_rf1", 5'd1, 32'd0);
    read_reg("midrst_rf6", 5'd6, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
